// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, oversampling ratio, parity encodings
// and the receiver state type.
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [1:0] ODD  = 2'b10;
  localparam logic [1:0] EVEN = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } rx_state_t;

  // Frame lengths outside 5..8 fall back to 8 data bits.
  function automatic logic [3:0] eff_len(input logic [3:0] fl);
    return ((fl >= 4'd5) && (fl <= 4'd8)) ? fl : 4'd8;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input.
// Both flops reset to 1, which matches the idle level of a UART line.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver that assembles several serial frames into one 32-bit word.
// Bits are sampled at 16x oversampling; RX_done pulses once per full word.
module uart_receiver
  import uart_pkg::*;
(
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  rx_tick,
  input  logic                  Rx,
  input  logic [3:0]            frame_length,
  input  logic [1:0]            parity_signal,
  input  logic                  stop_bits,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  RX_done,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  RX_ERROR
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [5:0] LAST_IDX  = 6'(DATA_WIDTH - 1);

  rx_state_t   state;
  rx_state_t   state_next;

  logic        rx_s;
  logic        rx_last;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [5:0]  index;
  logic        par_acc;
  logic [3:0]  cfg_len;
  logic [1:0]  cfg_par;
  logic        cfg_stop2;

  logic        fall;
  logic        mid_point;
  logic        bit_point;
  logic        last_bit;
  logic        last_frame;

  uart_sync2 u_sync (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .d     (Rx),
    .q     (rx_s)
  );

  // Sampling strobes derived from the tick counter and tick-rate edge detect.
  always_comb begin
    fall       = rx_tick && rx_last && !rx_s;
    mid_point  = rx_tick && (tick_cnt == MID_TICK);
    bit_point  = rx_tick && (tick_cnt == LAST_TICK);
    last_bit   = ({1'b0, bit_cnt} == (cfg_len - 4'd1));
    last_frame = (index >= LAST_IDX);
    RX_ERROR   = parity_error | frame_error;
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the word-complete strobe.
  always_comb begin
    state_next = state;
    RX_done    = 1'b0;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (mid_point) state_next = rx_s ? IDLE : DATA;
      DATA:   if (bit_point && last_bit)
                state_next = cfg_par[1] ? PARITY : STOP1;
      PARITY: if (bit_point) state_next = STOP1;
      STOP1:  if (bit_point) begin
                if (cfg_stop2)       state_next = STOP2;
                else if (last_frame) state_next = DONE;
                else                 state_next = IDLE;
              end
      STOP2:  if (bit_point) state_next = last_frame ? DONE : IDLE;
      DONE: begin
        RX_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: tick/bit counters, word assembly, config latch, sticky errors.
  // read_data and the error flags are only cleared by the first data sample
  // of the following word, so they stay readable after RX_done.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_last      <= 1'b1;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      index        <= '0;
      par_acc      <= 1'b0;
      cfg_len      <= 4'd8;
      cfg_par      <= '0;
      cfg_stop2    <= 1'b0;
      read_data    <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      if (rx_tick) rx_last <= rx_s;
      case (state)
        IDLE: begin
          if (fall) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            if (index == '0) begin
              cfg_len   <= eff_len(frame_length);
              cfg_par   <= parity_signal;
              cfg_stop2 <= stop_bits;
            end
          end
        end
        START: begin
          if (rx_tick) tick_cnt <= (tick_cnt == MID_TICK) ? '0 : tick_cnt + 4'd1;
        end
        DATA: begin
          if (rx_tick) tick_cnt <= tick_cnt + 4'd1;
          if (bit_point) begin
            bit_cnt <= bit_cnt + 3'd1;
            par_acc <= par_acc ^ rx_s;
            if (index != '1) index <= index + 6'd1;
            if (index == '0) begin
              read_data    <= {{(DATA_WIDTH-1){1'b0}}, rx_s};
              parity_error <= 1'b0;
              frame_error  <= 1'b0;
            end else if (index <= LAST_IDX) begin
              read_data[index[4:0]] <= rx_s;
            end
          end
        end
        PARITY: begin
          if (rx_tick) tick_cnt <= tick_cnt + 4'd1;
          // Odd parity expects data^parity == 1, even expects 0.
          if (bit_point && ((par_acc ^ rx_s) == cfg_par[0])) parity_error <= 1'b1;
        end
        STOP1, STOP2: begin
          if (rx_tick) tick_cnt <= tick_cnt + 4'd1;
          if (bit_point && !rx_s) frame_error <= 1'b1;
        end
        DONE: begin
          index <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: PCLK  input  1  system clock; PRESETn  input  1  async active-low reset.
REQ-002 SHALL provide rx_tick  input  1  single-PCLK enable pulse at 16x baud rate.
REQ-003 SHALL provide Rx  input  1  serial line, asynchronous to PCLK, idle high.
REQ-004 SHALL provide frame_length  input  4  data bits per frame; 5..8 legal.
REQ-005 SHALL provide parity_signal  input  2  [1] = parity enable; 2'b10 = odd, 2'b11 = even.
REQ-006 SHALL provide stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-007 SHALL provide read_data  output  DATA_WIDTH(32)  assembled word.
REQ-008 SHALL provide RX_done  output  1  one-PCLK pulse when read_data is valid.
REQ-009 SHALL provide parity_error, frame_error  output  1 each  sticky per word.
REQ-010 SHALL provide RX_ERROR  output  1  OR of parity_error and frame_error.

Function
REQ-011 SHALL pass Rx through a 2-flop synchronizer before any use.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, advancing only on rx_tick, except DONE, which lasts exactly one PCLK.
REQ-013 SHALL leave IDLE for START on a synchronized Rx falling edge, and reset a 4-bit tick counter to 0 on entry.
REQ-014 In START, SHALL resample Rx at tick 7 (mid-bit): if 1, return to IDLE (glitch rejection) with no flags changed; if 0, go to DATA.
REQ-015 SHALL sample every subsequent bit 16 ticks after the previous sample point.
REQ-016 SHALL store data bits LSB first, with frame data bit n written to read_data[index], where index is a 6-bit running count across frames; bits with index >= 32 are discarded.
REQ-017 SHALL leave DATA after frame_length samples, going to PARITY if parity_signal[1] is set, else to STOP1.
REQ-018 In PARITY, SHALL set parity_error if the XOR of the frame's data bits and the received parity bit is 0 for odd parity, or 1 for even parity.
REQ-019 In STOP1 and STOP2, SHALL set frame_error if the sampled stop bit is 0, and SHALL still continue the sequence.
REQ-020 SHALL go from STOP1 to STOP2 when stop_bits = 1.
REQ-021 After the final stop bit, SHALL go to DONE if index >= 31, else to IDLE to await the next frame of the same word.
REQ-022 In DONE, SHALL pulse RX_done for one PCLK with read_data and errors stable, then clear index and return to IDLE.
REQ-023 SHALL latch frame_length, parity_signal and stop_bits on the first start bit of a word (index = 0), and ignore changes to them until DONE.
REQ-024 SHALL treat frame_length outside 5..8 as 8.
REQ-025 SHALL hold read_data from DONE until the first data sample of the next word.
REQ-026 SHALL clear read_data, parity_error and frame_error when the next word's first data sample is stored.
REQ-027 Words per configuration: length 8 = 4 frames; length 5 = 7 frames; length 6 = 6 frames; length 7 = 5 frames.

Reset
REQ-028 On PRESETn low, SHALL asynchronously force state to IDLE and force all counters and read_data to 0.
REQ-029 On PRESETn low, SHALL force RX_done, parity_error, frame_error and RX_ERROR to 0.
REQ-030 On PRESETn low, SHALL preset both synchronizer flops to 1.
REQ-031 Reset mid-word SHALL discard the partial word, and no RX_done SHALL follow.

Structure
REQ-032 Shared uart_pkg SHALL hold DATA_WIDTH = 32, the rx state enum, the parity encodings ODD = 2'b10 and EVEN = 2'b11, and OVERSAMPLE = 16.
REQ-033 The synchronizer SHALL be the sub-module uart_sync2 (2-flop, reset value 1); all other logic SHALL be flat.

Verification
REQ-034 Bench SHALL cover: frame_length 8, no parity, 1 stop, four frames carrying 0xDEADBEEF -> one RX_done, read_data = 0xDEADBEEF, RX_ERROR = 0.
REQ-035 Bench SHALL cover: frame_length 5, even parity, 2 stop, word 0x12345678 over 7 frames -> read_data = 0x12345678, parity_error = 0.
REQ-036 Bench SHALL cover: frame_length 8, odd parity, one parity bit inverted in frame 2 -> parity_error = 1, RX_ERROR = 1 at RX_done, read_data still correct.
REQ-037 Bench SHALL cover: stop bit forced 0 in frame 1 -> frame_error = 1 at RX_done; next clean word -> errors 0.
REQ-038 Bench SHALL cover: Rx low pulse of 4 ticks -> returns to IDLE, no RX_done, no flags.
REQ-039 Bench SHALL cover: PRESETn low during frame 3 -> all outputs 0; subsequent full word 0xA5A5A5A5 -> received correctly.
